procyon_sync_fifo: RTL



---
 rtl/procyon_sync_fifo.sv | 90 +++++++++
 1 files changed

// File: rtl/procyon_sync_fifo.sv
// First-word-fall-through synchronous FIFO built from per-entry enabled flops.
// Status outputs are registered and derived from next-state pointers, so no input reaches them combinationally.
module procyon_sync_fifo #(
  parameter int OPTN_DATA_WIDTH = 8,
  parameter int OPTN_FIFO_DEPTH = 8
) (
  input  logic                                   clk,
  input  logic                                   n_rst,
  input  logic                                   i_flush,
  input  logic                                   i_fifo_wr_en,
  input  logic [OPTN_DATA_WIDTH-1:0]             i_fifo_wr_data,
  output logic                                   o_fifo_full,
  input  logic                                   i_fifo_ack,
  output logic                                   o_fifo_valid,
  output logic [OPTN_DATA_WIDTH-1:0]             o_fifo_data,
  output logic [$clog2(OPTN_FIFO_DEPTH+1)-1:0]   o_fifo_count
);

  localparam int ADDR_W = $clog2(OPTN_FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CNT_W  = $clog2(OPTN_FIFO_DEPTH + 1);

  logic [OPTN_DATA_WIDTH-1:0] r_storage [OPTN_FIFO_DEPTH];
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic                       r_valid;
  logic                       r_full;

  logic                       w_push;
  logic                       w_pop;
  logic [PTR_W-1:0]           w_wr_ptr_next;
  logic [PTR_W-1:0]           w_rd_ptr_next;
  logic [CNT_W-1:0]           w_count_next;
  logic                       w_valid_next;
  logic                       w_full_next;
  logic [OPTN_FIFO_DEPTH-1:0] w_entry_we;

  // Acceptance uses start-of-cycle flags only: full blocks writes, empty blocks acks.
  assign w_push = i_fifo_wr_en & ~r_full;
  assign w_pop  = i_fifo_ack & r_valid;

  always_comb begin
    w_wr_ptr_next = r_wr_ptr + PTR_W'(w_push);
    w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);
    w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    if (i_flush) begin
      w_wr_ptr_next = '0;
      w_rd_ptr_next = '0;
      w_count_next  = '0;
    end
    w_valid_next = (w_wr_ptr_next != w_rd_ptr_next);
    w_full_next  = (w_wr_ptr_next[ADDR_W-1:0] == w_rd_ptr_next[ADDR_W-1:0]) &&
                   (w_wr_ptr_next[PTR_W-1] != w_rd_ptr_next[PTR_W-1]);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_valid  <= w_valid_next;
      r_full   <= w_full_next;
    end
  end

  // Storage is never reset; occupancy is tracked solely by the pointers.
  generate
    for (genvar gi = 0; gi < OPTN_FIFO_DEPTH; gi++) begin : g_entry
      assign w_entry_we[gi] = w_push && (r_wr_ptr[ADDR_W-1:0] == ADDR_W'(gi));
      always_ff @(posedge clk) begin
        if (w_entry_we[gi]) begin
          r_storage[gi] <= i_fifo_wr_data;
        end
      end
    end
  endgenerate

  assign o_fifo_data  = r_storage[r_rd_ptr[ADDR_W-1:0]];
  assign o_fifo_valid = r_valid;
  assign o_fifo_full  = r_full;
  assign o_fifo_count = r_count;

endmodule
